// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - quadrature state encodings and transition classifier
package quad_pkg;

    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_01 = 2'b01;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_10 = 2'b10;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Position of a phase pair along the up cycle 00->10->11->01
    function automatic logic [1:0] quad_pos(input logic [1:0] s);
        case (s)
            QS_00:   quad_pos = 2'd0;
            QS_10:   quad_pos = 2'd1;
            QS_11:   quad_pos = 2'd2;
            default: quad_pos = 2'd3;
        endcase
    endfunction

    // Returns {legal, illegal, dir}; a half-cycle jump means both phases moved at once
    function automatic logic [2:0] quad_dir(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] delta;
        delta = quad_pos(cur) - quad_pos(prev);
        case (delta)
            2'd1:    quad_dir = {1'b1, 1'b0, DIR_UP};
            2'd3:    quad_dir = {1'b1, 1'b0, DIR_DN};
            2'd2:    quad_dir = {1'b0, 1'b1, DIR_DN};
            default: quad_dir = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/quad_filter.sv
// rtl/quad_filter.sv - synchroniser plus run-length glitch filter for one encoder phase
module quad_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic stable
);

    localparam int RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic [RUN_W-1:0]       run_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // fill_q marks when the synchroniser holds real pin samples rather than reset zeros
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            fill_q <= '0;
            run_q  <= '0;
            dout   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            if (synced == dout) begin
                run_q <= '0;
            end else if (run_q == RUN_LAST) begin
                dout  <= synced;
                run_q <= '0;
            end else begin
                run_q <= run_q + RUN_W'(1);
            end
        end
    end

    assign stable = fill_q[SYNC_STAGES-1] && (synced == dout);

endmodule

// File: rtl/quadrature_decoder.sv
// rtl/quadrature_decoder.sv - A/B quadrature decoder with step pulse, direction and position count
module quadrature_decoder #(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 err_clr,
    input  logic                 quad_a,
    input  logic                 quad_b,
    output logic                 step,
    output logic                 up_down,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 err
);

    import quad_pkg::*;

    logic       a_f, b_f, a_stable, b_stable;
    logic       primed;
    logic [1:0] prev_state, cur_state;
    logic       legal, illegal, dir;

    quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk(clk), .reset(reset), .din(quad_a), .dout(a_f), .stable(a_stable)
    );

    quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk(clk), .reset(reset), .din(quad_b), .dout(b_f), .stable(b_stable)
    );

    assign cur_state = {a_f, b_f};
    assign {legal, illegal, dir} = quad_dir(prev_state, cur_state);

    // Until primed, prev_state is meaningless, so no step or err may be derived from it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            primed     <= 1'b0;
            prev_state <= QS_00;
            step       <= 1'b0;
            up_down    <= DIR_UP;
            count      <= '0;
            err        <= 1'b0;
        end else begin
            step <= 1'b0;
            if (!primed) begin
                if (a_stable && b_stable) begin
                    primed     <= 1'b1;
                    prev_state <= cur_state;
                end
            end else begin
                prev_state <= cur_state;
                if (legal && enable) begin
                    step    <= 1'b1;
                    up_down <= dir;
                    count   <= (dir == DIR_UP) ? count + CNT_WIDTH'(1) : count - CNT_WIDTH'(1);
                end
            end
            if (clear) begin
                count <= '0;
            end
            if (primed && illegal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb/tb_quadrature_decoder.sv - self-checking bench for quadrature_decoder
module tb_quadrature_decoder;

    logic        clk = 1'b0;
    logic        reset, enable, clear, err_clr, quad_a, quad_b;
    logic        step, up_down, err;
    logic [15:0] count;

    int errors = 0;
    int checks = 0;
    int steps_seen = 0;

    always #5 clk = ~clk;

    quadrature_decoder #(.CNT_WIDTH(16), .SYNC_STAGES(2), .FILTER_LEN(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .err_clr(err_clr),
        .quad_a(quad_a), .quad_b(quad_b), .step(step), .up_down(up_down),
        .count(count), .err(err)
    );

    typedef struct {
        logic [1:0]  ab;
        logic        en;
        logic        clr;
        logic        eclr;
        int          hold;
        logic [15:0] exp_count;
        logic        exp_ud;
        logic        exp_err;
        int          exp_steps;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
        if (step) steps_seen++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic move(input logic [1:0] ab, input int n);
        {quad_a, quad_b} = ab;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {quad_a, quad_b} = 2'b00;
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
    endtask

    // Reference model: position along the up cycle, independent of the design encoding
    logic [1:0]  seq[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0]  m_raw;
    logic [15:0] m_pos;
    logic        m_ud, m_err, m_en;

    function automatic int seq_idx(input logic [1:0] s);
        for (int i = 0; i < 4; i++) if (seq[i] == s) return i;
        return 0;
    endfunction

    initial begin
        int lat;
        reset = 1'b1; enable = 1'b1; clear = 1'b0; err_clr = 1'b0;
        quad_a = 1'b0; quad_b = 1'b0;
        repeat (3) tick();
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_up_down", 32'(up_down), 32'h1);
        chk("reset_step", 32'(step), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        reset = 1'b0;

        vecs[0]  = '{2'b00, 1'b1, 1'b0, 1'b0, 20, 16'h0000, 1'b1, 1'b0, 0};
        vecs[1]  = '{2'b10, 1'b1, 1'b0, 1'b0, 10, 16'h0001, 1'b1, 1'b0, 1};
        vecs[2]  = '{2'b11, 1'b1, 1'b0, 1'b0, 10, 16'h0002, 1'b1, 1'b0, 1};
        vecs[3]  = '{2'b01, 1'b1, 1'b0, 1'b0, 10, 16'h0003, 1'b1, 1'b0, 1};
        vecs[4]  = '{2'b00, 1'b1, 1'b0, 1'b0, 10, 16'h0004, 1'b1, 1'b0, 1};
        vecs[5]  = '{2'b00, 1'b1, 1'b1, 1'b0, 10, 16'h0000, 1'b1, 1'b0, 0};
        vecs[6]  = '{2'b01, 1'b1, 1'b0, 1'b0, 10, 16'hFFFF, 1'b0, 1'b0, 1};
        vecs[7]  = '{2'b11, 1'b1, 1'b0, 1'b0, 10, 16'hFFFE, 1'b0, 1'b0, 1};
        vecs[8]  = '{2'b10, 1'b1, 1'b0, 1'b0, 10, 16'hFFFD, 1'b0, 1'b0, 1};
        vecs[9]  = '{2'b00, 1'b1, 1'b0, 1'b0, 10, 16'hFFFC, 1'b0, 1'b0, 1};
        vecs[10] = '{2'b11, 1'b1, 1'b0, 1'b0, 10, 16'hFFFC, 1'b0, 1'b1, 0};
        vecs[11] = '{2'b11, 1'b1, 1'b0, 1'b1, 10, 16'hFFFC, 1'b0, 1'b0, 0};
        vecs[12] = '{2'b01, 1'b0, 1'b0, 1'b0, 10, 16'hFFFC, 1'b0, 1'b0, 0};
        vecs[13] = '{2'b00, 1'b0, 1'b0, 1'b0, 10, 16'hFFFC, 1'b0, 1'b0, 0};
        vecs[14] = '{2'b00, 1'b1, 1'b0, 1'b0, 10, 16'hFFFC, 1'b0, 1'b0, 0};
        vecs[15] = '{2'b10, 1'b1, 1'b0, 1'b0, 10, 16'hFFFD, 1'b1, 1'b0, 1};

        for (int i = 0; i < 16; i++) begin
            {quad_a, quad_b} = vecs[i].ab;
            enable = vecs[i].en; clear = vecs[i].clr; err_clr = vecs[i].eclr;
            steps_seen = 0;
            tick();
            clear = 1'b0; err_clr = 1'b0;
            repeat (vecs[i].hold - 1) tick();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_up_down", i), 32'(up_down), 32'(vecs[i].exp_ud));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_steps", i), 32'(steps_seen), 32'(vecs[i].exp_steps));
        end

        // Latency from raw A edge to step
        enable = 1'b1;
        do_reset();
        quad_a = 1'b1;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (step) begin lat = n; break; end
        end
        chk("step_latency", 32'(lat), 32'd7);
        chk("latency_count", 32'(count), 32'h1);
        repeat (10) tick();

        // Two-cycle glitch on A is filtered out
        steps_seen = 0;
        quad_a = 1'b0;
        repeat (2) tick();
        quad_a = 1'b1;
        repeat (15) tick();
        chk("glitch_steps", 32'(steps_seen), 32'h0);
        chk("glitch_count", 32'(count), 32'h1);

        // clear coinciding with the step cycle
        quad_b = 1'b1;
        repeat (6) tick();
        clear = 1'b1;
        tick();
        chk("clear_step", 32'(step), 32'h1);
        chk("clear_count", 32'(count), 32'h0);
        clear = 1'b0;
        repeat (10) tick();

        // Reset mid-sequence with A=B=1, then re-prime on 11
        move(2'b01, 12); move(2'b00, 12); move(2'b10, 12); move(2'b11, 12);
        chk("pre_reset_count", 32'(count), 32'h4);
        reset = 1'b1;
        #2;
        chk("midrst_count", 32'(count), 32'h0);
        chk("midrst_up_down", 32'(up_down), 32'h1);
        chk("midrst_err", 32'(err), 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        steps_seen = 0;
        repeat (20) tick();
        chk("reprime_steps", 32'(steps_seen), 32'h0);
        chk("reprime_err", 32'(err), 32'h0);
        move(2'b01, 12);
        chk("reprime_move_count", 32'(count), 32'h1);
        chk("reprime_move_up_down", 32'(up_down), 32'h1);

        // Randomized segments against the event-level model
        m_raw = 2'b01; m_pos = 16'h1; m_ud = 1'b1; m_err = 1'b0; m_en = 1'b1;
        for (int s = 0; s < 80; s++) begin
            int r, idx, exp_steps;
            r = $urandom_range(0, 7);
            idx = seq_idx(m_raw);
            exp_steps = 0;
            steps_seen = 0;
            case (r)
                0, 1, 2, 3: begin
                    m_raw = (r < 2) ? seq[(idx + 1) % 4] : seq[(idx + 3) % 4];
                    if (m_en) begin
                        exp_steps = 1;
                        m_ud = (r < 2);
                        m_pos = (r < 2) ? m_pos + 16'h1 : m_pos - 16'h1;
                    end
                    move(m_raw, 12);
                end
                4: begin
                    m_raw = ~m_raw;
                    m_err = 1'b1;
                    move(m_raw, 12);
                end
                5: begin
                    int w;
                    logic [1:0] g;
                    w = $urandom_range(1, 3);
                    g = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
                    move(m_raw ^ g, w);
                    move(m_raw, 12);
                end
                6: begin
                    m_en = 1'($urandom_range(0, 1));
                    enable = m_en;
                    tick();
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        clear = 1'b1; m_pos = 16'h0;
                    end else begin
                        err_clr = 1'b1; m_err = 1'b0;
                    end
                    tick();
                    clear = 1'b0; err_clr = 1'b0;
                    repeat (4) tick();
                end
            endcase
            chk($sformatf("rnd%0d_count", s), 32'(count), 32'(m_pos));
            chk($sformatf("rnd%0d_up_down", s), 32'(up_down), 32'(m_ud));
            chk($sformatf("rnd%0d_err", s), 32'(err), 32'(m_err));
            chk($sformatf("rnd%0d_steps", s), 32'(steps_seen), 32'(exp_steps));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
